// File: rtl/regfile_wb_queue.sv
// Write-back queue feeding the regFile write port: arbitrates ALU (A) and load (B) results into an
// in-order FIFO and drains one registered write per cycle. Optional lookup port under REGFILE_WB_FWD_EN.
module regfile_wb_queue #(
    parameter int WORD_LEN   = 32,
    parameter int ADDR_LEN   = 5,
    parameter int DEPTH      = 4,
    parameter int STARVE_LIM = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         a_valid,
    output logic                         a_ready,
    input  logic [ADDR_LEN-1:0]          a_addr,
    input  logic [WORD_LEN-1:0]          a_data,
    input  logic                         b_valid,
    output logic                         b_ready,
    input  logic [ADDR_LEN-1:0]          b_addr,
    input  logic [WORD_LEN-1:0]          b_data,
    input  logic                         drain_en,
    output logic                         rf_wen,
    output logic [ADDR_LEN-1:0]          rf_addr,
    output logic [WORD_LEN-1:0]          rf_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef REGFILE_WB_FWD_EN
    ,
    input  logic [ADDR_LEN-1:0]          fwd_addr,
    output logic                         fwd_hit,
    output logic [WORD_LEN-1:0]          fwd_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int SC_W  = $clog2(STARVE_LIM + 1);

    logic [ADDR_LEN-1:0] mem_addr [DEPTH];
    logic [WORD_LEN-1:0] mem_data [DEPTH];

    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [SC_W-1:0]     starve_cnt;

    logic                full;
    logic                starved;
    logic                push_a;
    logic                push_b;
    logic                push;
    logic                pop;
    logic [ADDR_LEN-1:0] push_addr;
    logic [WORD_LEN-1:0] push_data;

    // A normally wins; once B has lost STARVE_LIM times in a row it takes the slot.
    always_comb begin
        full      = (occupancy == OCC_W'(DEPTH));
        starved   = (starve_cnt >= SC_W'(STARVE_LIM));
        a_ready   = !full && !(starved && b_valid);
        b_ready   = !full && (!a_valid || starved);
        push_a    = a_valid && a_ready;
        push_b    = b_valid && b_ready;
        push      = push_a || push_b;
        pop       = drain_en && (occupancy != '0);
        push_addr = push_b ? b_addr : a_addr;
        push_data = push_b ? b_data : a_data;
    end

    // NOTE: storage array is not reset; entries are only ever read when counted by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[tail] <= push_addr;
            mem_data[tail] <= push_data;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (b_valid && !b_ready && !full) begin
            if (!starved) starve_cnt <= starve_cnt + 1'b1;
        end else if (!b_valid || push_b) begin
            starve_cnt <= '0;
        end
    end

    // Address/data hold their last value when idle; only rf_wen returns low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen  <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else if (pop) begin
            rf_wen  <= 1'b1;
            rf_addr <= mem_addr[head];
            rf_data <= mem_data[head];
        end else begin
            rf_wen  <= 1'b0;
        end
    end

`ifdef REGFILE_WB_FWD_EN
    // Scan oldest to youngest so the last assignment is the youngest pending write.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (rf_wen && (rf_addr == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = rf_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if ((OCC_W'(i) < occupancy) && (mem_addr[head + PTR_W'(i)] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_data[head + PTR_W'(i)];
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue: directed stimulus pushes hand-computed writes into an
// expected queue; a monitor pops and compares every rf_wen pulse.
module tb_regfile_wb_queue;

    localparam int WORD_LEN   = 32;
    localparam int ADDR_LEN   = 5;
    localparam int DEPTH      = 4;
    localparam int STARVE_LIM = 3;
    localparam int OCC_W      = $clog2(DEPTH + 1);

    typedef struct {
        logic [ADDR_LEN-1:0] addr;
        logic [WORD_LEN-1:0] data;
    } wb_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                a_valid, a_ready, b_valid, b_ready, drain_en, rf_wen;
    logic [ADDR_LEN-1:0] a_addr, b_addr, rf_addr;
    logic [WORD_LEN-1:0] a_data, b_data, rf_data;
    logic [OCC_W-1:0]    occupancy;
`ifdef REGFILE_WB_FWD_EN
    logic [ADDR_LEN-1:0] fwd_addr;
    logic                fwd_hit;
    logic [WORD_LEN-1:0] fwd_data;
`endif

    int  checks = 0;
    int  errors = 0;
    wb_t exp_q[$];
    wb_t mon_e;

    regfile_wb_queue #(
        .WORD_LEN(WORD_LEN), .ADDR_LEN(ADDR_LEN), .DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .drain_en(drain_en),
        .rf_wen(rf_wen), .rf_addr(rf_addr), .rf_data(rf_data),
        .occupancy(occupancy)
`ifdef REGFILE_WB_FWD_EN
        ,
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input int addr, input int data);
        wb_t e;
        e.addr = ADDR_LEN'(addr);
        e.data = WORD_LEN'(data);
        exp_q.push_back(e);
    endtask

    task automatic wait_drained();
        int n = 0;
        while ((occupancy != '0 || rf_wen) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("drain_done_occ", 32'(occupancy), 0);
        check("drain_done_exp_left", exp_q.size(), 0);
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && rf_wen) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got write r%0d=%0h, required no write", rf_addr, rf_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_addr", 32'(rf_addr), 32'(mon_e.addr));
                check("wb_data", rf_data, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    localparam logic [7:0] T3_A_RDY = 8'b0111_0111;
    localparam logic [7:0] T3_B_RDY = 8'b1000_1000;

    initial begin
        logic [7:0] a_tab, b_tab;
        rst_n = 1'b0; a_valid = 0; b_valid = 0; drain_en = 0;
        a_addr = '0; a_data = '0; b_addr = '0; b_data = '0;
`ifdef REGFILE_WB_FWD_EN
        fwd_addr = '0;
`endif
        #2;
        check("rst_wen", 32'(rf_wen), 0);
        check("rst_addr", 32'(rf_addr), 0);
        check("rst_data", rf_data, 0);
        check("rst_occ", 32'(occupancy), 0);
        check("rst_a_ready", 32'(a_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: single write, two-edge latency, one cycle wide
        @(negedge clk);
        a_valid = 1; a_addr = 3; a_data = 32'h11; drain_en = 1;
        expect_wb(3, 32'h11);
        #1 check("t1_a_ready", 32'(a_ready), 1);
        @(negedge clk);
        a_valid = 0;
        check("t1_wen_edge1", 32'(rf_wen), 0);
        check("t1_occ_edge1", 32'(occupancy), 1);
        @(negedge clk);
        check("t1_wen_edge2", 32'(rf_wen), 1);
        check("t1_addr_edge2", 32'(rf_addr), 3);
        check("t1_data_edge2", rf_data, 32'h11);
        @(negedge clk);
        check("t1_wen_edge3", 32'(rf_wen), 0);
        check("t1_addr_hold", 32'(rf_addr), 3);

        // 2 + 4: fill to full, fifth held, no push-through on a popping cycle
        drain_en = 0;
        for (int i = 1; i <= 4; i++) begin
            a_valid = 1; a_addr = ADDR_LEN'(i); a_data = 32'h100 + i;
            expect_wb(i, 32'h100 + i);
            @(negedge clk);
        end
        a_addr = 5; a_data = 32'h105;
        expect_wb(5, 32'h105);
        #1;
        check("t2_occ_full", 32'(occupancy), 4);
        check("t2_a_ready_full", 32'(a_ready), 0);
        check("t2_b_ready_full", 32'(b_ready), 0);
        @(negedge clk);
        check("t2_occ_held", 32'(occupancy), 4);
        check("t2_no_write", 32'(rf_wen), 0);
        drain_en = 1;
        #1 check("t4_no_push_through", 32'(a_ready), 0);
        @(negedge clk);
        check("t4_occ_after_pop", 32'(occupancy), 3);
        drain_en = 0;
        #1 check("t4_a_ready_next", 32'(a_ready), 1);
        @(negedge clk);
        check("t4_occ_refilled", 32'(occupancy), 4);
        a_valid = 0; drain_en = 1;
        wait_drained();

        // 3: A and B both valid; B gets the slot every fourth cycle
        drain_en = 1;
        expect_wb(7, 0); expect_wb(7, 1); expect_wb(7, 2); expect_wb(9, 32'hB0);
        expect_wb(7, 4); expect_wb(7, 5); expect_wb(7, 6); expect_wb(9, 32'hB1);
        a_tab = T3_A_RDY;
        b_tab = T3_B_RDY;
        for (int k = 0; k < 8; k++) begin
            a_valid = 1; a_addr = 7; a_data = k;
            b_valid = 1; b_addr = 9; b_data = (k < 4) ? 32'hB0 : 32'hB1;
            #1;
            check($sformatf("t3_a_ready_%0d", k), 32'(a_ready), 32'(a_tab[k]));
            check($sformatf("t3_b_ready_%0d", k), 32'(b_ready), 32'(b_tab[k]));
            @(negedge clk);
        end
        a_valid = 0; b_valid = 0;
        wait_drained();

        // 5: reset with a write in flight and three queued
        drain_en = 0;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1; a_addr = ADDR_LEN'(10 + i); a_data = 32'h200 + i;
            expect_wb(10 + i, 32'h200 + i);
            @(negedge clk);
        end
        a_valid = 0; drain_en = 1;
        @(negedge clk);
        #2;
        check("t5_occ_before", 32'(occupancy), 3);
        rst_n = 0;
        #1;
        check("t5_wen_in_reset", 32'(rf_wen), 0);
        check("t5_occ_in_reset", 32'(occupancy), 0);
        check("t5_addr_in_reset", 32'(rf_addr), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1;
        repeat (5) @(negedge clk);
        check("t5_occ_after", 32'(occupancy), 0);
        check("t5_wen_after", 32'(rf_wen), 0);

`ifdef REGFILE_WB_FWD_EN
        // 6: youngest pending write to the same register wins
        drain_en = 0;
        a_valid = 1; a_addr = 5; a_data = 32'hA; expect_wb(5, 32'hA);
        @(negedge clk);
        a_data = 32'hB; expect_wb(5, 32'hB);
        @(negedge clk);
        a_valid = 0;
        fwd_addr = 5;
        #1;
        check("t6_hit5", 32'(fwd_hit), 1);
        check("t6_data5", fwd_data, 32'hB);
        fwd_addr = 6;
        #1;
        check("t6_hit6", 32'(fwd_hit), 0);
        check("t6_data6", fwd_data, 0);
        fwd_addr = 5; drain_en = 1;
        @(negedge clk);
        check("t6_hit_stage_and_fifo", 32'(fwd_data), 32'hB);
        @(negedge clk);
        check("t6_hit_stage_only", 32'(fwd_hit), 1);
        check("t6_data_stage_only", fwd_data, 32'hB);
        @(negedge clk);
        check("t6_hit_none", 32'(fwd_hit), 0);
        wait_drained();
`endif

        check("final_exp_left", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
